// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The optional perf counters are enabled with FETCH_PERF_CNT_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_skid.sv
// Single-entry holding register for a response that arrives while
// decode is stalled on an occupied IF/ID slot.
module fetch_skid
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic              drain,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= DATA_W'(NOP_INSTR);
            pc    <= '0;
        end else if (clear || drain) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC owner, single-outstanding imem reader, IF/ID slot.
// Define FETCH_PERF_CNT_EN to build the fetched/bubble performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_id_valid,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc_next,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles
);

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] inflight_pc;
    logic [ADDR_W-1:0] inflight_d;
    logic              kill;
    logic              kill_d;
    logic              valid_d;
    logic [DATA_W-1:0] instr_d;
    logic [ADDR_W-1:0] pc_next_d;
    logic [ADDR_W-1:0] rsp_pc;
    logic              slot_free;
    logic              skid_load;
    logic              skid_clear;
    logic              skid_drain;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [ADDR_W-1:0] skid_pc;

    assign imem_req_valid = (state == REQ) && !redirect_valid;
    assign imem_req_addr  = pc;
    assign pc_o           = pc;
    assign rsp_pc         = inflight_pc + ADDR_W'(PC_INC);
    assign slot_free      = !if_id_valid || !stall;

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        inflight_d = inflight_pc;
        kill_d     = kill;
        valid_d    = if_id_valid;
        instr_d    = if_id_instr;
        pc_next_d  = if_id_pc_next;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        skid_drain = 1'b0;

        // Without a new instruction the slot either holds or drains to a bubble.
        if (!stall) begin
            valid_d = 1'b0;
            instr_d = DATA_W'(NOP_INSTR);
        end

        unique case (state)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_req_valid && imem_req_ready) begin
                    inflight_d = pc;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else if (slot_free) begin
                        valid_d   = 1'b1;
                        instr_d   = imem_rsp_data;
                        pc_next_d = rsp_pc;
                        pc_d      = rsp_pc;
                        state_d   = REQ;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    skid_drain = 1'b1;
                    valid_d    = skid_valid;
                    instr_d    = skid_data;
                    pc_next_d  = skid_pc;
                    pc_d       = skid_pc;
                    state_d    = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect wins over everything, including stall.
        if (redirect_valid) begin
            valid_d    = 1'b0;
            instr_d    = DATA_W'(NOP_INSTR);
            pc_next_d  = if_id_pc_next;
            pc_d       = {redirect_pc[ADDR_W-1:2], 2'b00};
            inflight_d = inflight_pc;
            skid_load  = 1'b0;
            skid_drain = 1'b0;
            skid_clear = 1'b1;
            kill_d     = kill;
            unique case (state)
                WAIT: begin
                    if (imem_rsp_valid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = WAIT;
                    end
                end
                HOLD:    state_d = REQ;
                REQ:     state_d = REQ;
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            inflight_pc   <= '0;
            kill          <= 1'b0;
            if_id_valid   <= 1'b0;
            if_id_instr   <= DATA_W'(NOP_INSTR);
            if_id_pc_next <= '0;
        end else begin
            state         <= state_d;
            pc            <= pc_d;
            inflight_pc   <= inflight_d;
            kill          <= kill_d;
            if_id_valid   <= valid_d;
            if_id_instr   <= instr_d;
            if_id_pc_next <= pc_next_d;
        end
    end

    fetch_skid #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .clear    (skid_clear),
        .drain    (skid_drain),
        .load_data(imem_rsp_data),
        .load_pc  (rsp_pc),
        .valid    (skid_valid),
        .data     (skid_data),
        .pc       (skid_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] bubbles_q;
    logic        fetch_load;

    // A valid next slot that is not a stalled hold is a fresh load.
    assign fetch_load = valid_d && !(if_id_valid && stall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (fetch_load) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (!if_id_valid && !stall) begin
                bubbles_q <= bubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`else
    assign perf_fetched = '0;
    assign perf_bubbles = '0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage feeding the datapath's IF/ID boundary.
- Owns the PC and issues one instruction-memory read at a time over a valid/ready request with a single-pulse response.
- Presents the fetched instruction and PC+4 to decode in a registered IF/ID slot.
- Supports stall (hold), and redirect from branch/jump resolution (flush and re-steer).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC / memory address width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  read address; equals pc.
- imem_rsp_valid  in  1  one-cycle pulse; response data valid.
- imem_rsp_data  in  DATA_W  instruction word.
- stall  in  1  decode cannot accept; IF/ID holds.
- redirect_valid  in  1  branch/jump taken; flush and re-steer.
- redirect_pc  in  ADDR_W  new PC target.
- if_id_valid  out  1  IF/ID slot holds a real instruction.
- if_id_instr  out  DATA_W  fetched instruction (NOP when invalid).
- if_id_pc_next  out  ADDR_W  fetch address + 4.
- pc_o  out  ADDR_W  current PC, debug.
- perf_fetched  out  32  optional counter (see below).
- perf_bubbles  out  32  optional counter (see below).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, state=IDLE, kill=0, skid empty.
  - if_id_valid=0, if_id_instr=NOP (32'h0), if_id_pc_next=0, imem_req_valid=0.
- FSM states: IDLE, REQ, WAIT, HOLD. One outstanding request maximum.
- IDLE: unconditionally goes to REQ on the next clock. The first request is issued in the 2nd cycle after reset release.
- REQ:
  - imem_req_valid = (state==REQ) && !redirect_valid.
  - imem_req_addr = pc.
  - On handshake: latch inflight_pc=pc, go to WAIT.
- WAIT, on imem_rsp_valid:
  - kill=1: discard the response, clear kill, go to REQ.
  - Slot free (if_id_valid=0 or stall=0): load IF/ID with valid=1, instr=rsp_data, pc_next=inflight_pc+4. Set pc=inflight_pc+4, go to REQ.
  - Slot occupied and stall=1: capture into skid, go to HOLD.
- HOLD: when stall=0, move skid into IF/ID, set pc=inflight_pc+4, go to REQ.
- IF/ID update when no new instruction arrives:
  - stall=1: all IF/ID outputs hold.
  - stall=0: if_id_valid<=0 and instr<=NOP (bubble); pc_next holds.
- Redirect (highest priority, overrides stall):
  - IF/ID flushed: valid=0, instr=NOP.
  - pc<=redirect_pc with bits[1:0] forced to 0. Skid cleared.
  - In WAIT: kill<=1 and stay in WAIT. A response arriving in the same cycle is discarded; go to REQ with kill=0.
  - In HOLD: go to REQ.
  - In REQ: no handshake that cycle; stay in REQ.
  - The first request after a redirect appears on the next cycle.
- PC arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0.
- imem_rsp_valid outside WAIT is ignored.
- imem_req_valid, once asserted, stays asserted with a stable address until handshake or redirect.
- Reset asserted mid-transaction aborts everything. A late response after reset is ignored because the state is no longer WAIT.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - perf_fetched increments on every IF/ID load with valid=1.
  - perf_bubbles increments each cycle that if_id_valid=0 and stall=0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: both ports are driven constant 0 and no counter flops are built.

Decomposition:
- Package fetch_pkg holds:
  - state enum {IDLE, REQ, WAIT, HOLD};
  - NOP_INSTR = 32'h0;
  - PC_INC = 4.
- Sub-module fetch_skid: single-entry holding register with data, pc and valid, with load, clear and drain controls.

Test Plan:
- Reset with RESET_PC=0x100, memory ready=1, 1-cycle latency, no stall → addresses 0x100, 0x104, 0x108 issued; if_id_pc_next 0x104, 0x108; if_id_valid=1 after each rsp.
- Hold imem_req_ready=0 for 3 cycles → req_valid stays 1 with addr constant; no IF/ID update; bubbles counted if FETCH_PERF_CNT_EN.
- stall=1 while IF/ID holds an instruction and rsp 0x8C220004 arrives → IF/ID unchanged, FSM in HOLD; stall=0 → IF/ID=0x8C220004 next cycle.
- redirect_valid with redirect_pc=0x203 while in WAIT; rsp arrives 2 cycles later → rsp discarded, next req addr=0x200, IF/ID flushed to valid=0/NOP.
- PC at 0xFFFFFFFC fetched → if_id_pc_next=0x0 and next request addr=0x0.
- Assert rst_n=0 during WAIT, then pulse imem_rsp_valid → outputs at reset values immediately, response ignored, first req at RESET_PC.
